multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences the shared datapath (PC, instruction register, register file and one ALU) across fetch, decode, execute, memory and writeback cycles.
- Drives alu_op[1:0] into the existing ALU decoder, along with all datapath mux selects and write strobes.
- Supports a memory-ready handshake so instruction/data memory may take several cycles.

---
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional retire/cycle counters are built when MC_PERF_CNT_EN is defined.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] imm_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       reg_write,
   output logic       fault
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] cycle_cnt
`endif
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_FAULT
   } state_e;

   state_e          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            wait_st;
   logic            wd_expire;
   logic            br_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      wait_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
      wd_expire = (MEM_TIMEOUT > 0) && wait_st && !mem_ready && (wd_q == WD_LAST);
      br_valid  = (funct3[2:1] == 2'b00);
      state_d   = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FAULT;
            endcase
         end
         S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = br_valid ? S_FETCH : S_FAULT;
         S_JAL:    state_d = S_FETCH;
         default:  state_d = S_FAULT;
      endcase
      // A late mem_ready still wins because expiry requires mem_ready low.
      if (wd_expire) state_d = S_FAULT;

      wd_d = wd_q;
      if (MEM_TIMEOUT == 0 || state_d != state_q) wd_d = '0;
      else if (wait_st && !mem_ready) wd_d = wd_q + 1'b1;
   end

   always_comb begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      imm_src    = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      reg_write  = 1'b0;
      fault      = (state_q == S_FAULT);
      case (state_q)
         S_FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 2'b10;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
         end
         S_MEMRD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
         end
         S_MEMWR: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB:  reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_write  = br_valid && (zero ^ funct3[0]);
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            imm_src   = 2'b11;
            pc_write  = 1'b1;
            reg_write = 1'b1;
         end
         default: ;
      endcase
      if (rst) begin
         pc_write   = 1'b0;
         adr_src    = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         imm_src    = 2'b00;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b10;
         alu_op     = 2'b00;
         result_src = 2'b10;
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] retired_q, cycle_q;
   logic             retire;

   always_comb begin
      retire = (state_d == S_FETCH) &&
               ((state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                (state_q == S_BRANCH) || (state_q == S_JAL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         retired_q <= '0;
         cycle_q   <= '0;
      end else begin
         cycle_q <= cycle_q + CNT_W'(1);
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign retired_cnt = retired_q;
   assign cycle_cnt   = cycle_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks every instruction class, branch cases,
// faults, watchdog expiry and (when MC_PERF_CNT_EN is defined) the wrapping counters.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // {pc_write, adr_src, mem_write, ir_write, imm_src, alu_src_a, alu_src_b, alu_op, result_src, reg_write, fault}
   localparam logic [15:0] V_RESET     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
   localparam logic [15:0] V_FETCH_GO  = {1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
   localparam logic [15:0] V_FETCH_W   = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
   localparam logic [15:0] V_DECODE    = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_EXECR     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_EXECI     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_ALUWB     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [15:0] V_MEMADR_LW = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_MEMADR_SW = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_MEMRD     = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_MEMWB     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0};
   localparam logic [15:0] V_MEMWR     = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_BR_T      = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_BR_N      = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,2'b00,1'b0,1'b0};
   localparam logic [15:0] V_JAL       = {1'b1,1'b0,1'b0,1'b0,2'b11,2'b01,2'b10,2'b00,2'b00,1'b1,1'b0};
   localparam logic [15:0] V_FAULT     = 16'h0001;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, fault;
   logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
   logic [15:0] obs;
`ifdef MC_PERF_CNT_EN
   logic [3:0] retired_cnt, cycle_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .reg_write(reg_write), .fault(fault)
`ifdef MC_PERF_CNT_EN
      , .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
`endif
   );

   assign obs = {pc_write, adr_src, mem_write, ir_write, imm_src, alu_src_a, alu_src_b,
                 alu_op, result_src, reg_write, fault};

   // Advance one clock, then apply this cycle's inputs and let the outputs settle.
   task automatic cy(input logic r, input logic mr, input logic [6:0] o,
                     input logic [2:0] f3, input logic z);
      @(posedge clk);
      #1;
      rst = r; mem_ready = mr; op = o; funct3 = f3; zero = z;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000; zero = 1'b0;

      cy(1, 1, OP_R, 0, 0);   chk("rst_c1", obs, V_RESET);
      cy(1, 1, OP_R, 0, 0);   chk("rst_c2", obs, V_RESET);
`ifdef MC_PERF_CNT_EN
      chk("rst_retired", retired_cnt, 0);
      chk("rst_cycle", cycle_cnt, 0);
`endif
      // R-type: 4 cycles
      cy(0, 1, OP_R, 0, 0);   chk("r_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_R, 0, 0);   chk("r_decode", obs, V_DECODE);
      cy(0, 1, OP_R, 0, 0);   chk("r_execr", obs, V_EXECR);
      cy(0, 1, OP_R, 0, 0);   chk("r_aluwb", obs, V_ALUWB);
      // lw with three wait cycles in MEMRD
      cy(0, 1, OP_LW, 0, 0);  chk("lw_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_LW, 0, 0);  chk("lw_decode", obs, V_DECODE);
      cy(0, 1, OP_LW, 0, 0);  chk("lw_memadr", obs, V_MEMADR_LW);
      cy(0, 0, OP_LW, 0, 0);  chk("lw_memrd1", obs, V_MEMRD);
      cy(0, 0, OP_LW, 0, 0);  chk("lw_memrd2", obs, V_MEMRD);
      cy(0, 0, OP_LW, 0, 0);  chk("lw_memrd3", obs, V_MEMRD);
      cy(0, 1, OP_LW, 0, 0);  chk("lw_memrd4", obs, V_MEMRD);
      cy(0, 1, OP_LW, 0, 0);  chk("lw_memwb", obs, V_MEMWB);
      // sw with one wait cycle
      cy(0, 1, OP_SW, 0, 0);  chk("sw_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_SW, 0, 0);  chk("sw_decode", obs, V_DECODE);
      cy(0, 1, OP_SW, 0, 0);  chk("sw_memadr", obs, V_MEMADR_SW);
      cy(0, 0, OP_SW, 0, 0);  chk("sw_memwr1", obs, V_MEMWR);
      cy(0, 1, OP_SW, 0, 0);  chk("sw_memwr2", obs, V_MEMWR);
      // I-type
      cy(0, 1, OP_I, 0, 0);   chk("i_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_I, 0, 0);   chk("i_decode", obs, V_DECODE);
      cy(0, 1, OP_I, 0, 0);   chk("i_execi", obs, V_EXECI);
      cy(0, 1, OP_I, 0, 0);   chk("i_aluwb", obs, V_ALUWB);
      // beq taken / not taken, bne taken / not taken
      cy(0, 1, OP_BR, 0, 1);  chk("beq_t_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_BR, 0, 1);  chk("beq_t_decode", obs, V_DECODE);
      cy(0, 1, OP_BR, 0, 1);  chk("beq_taken", obs, V_BR_T);
      cy(0, 1, OP_BR, 0, 0);  cy(0, 1, OP_BR, 0, 0);
      cy(0, 1, OP_BR, 0, 0);  chk("beq_not_taken", obs, V_BR_N);
      cy(0, 1, OP_BR, 1, 0);  cy(0, 1, OP_BR, 1, 0);
      cy(0, 1, OP_BR, 1, 0);  chk("bne_taken", obs, V_BR_T);
      cy(0, 1, OP_BR, 1, 1);  cy(0, 1, OP_BR, 1, 1);
      cy(0, 1, OP_BR, 1, 1);  chk("bne_not_taken", obs, V_BR_N);
      // jal
      cy(0, 1, OP_JAL, 0, 0); cy(0, 1, OP_JAL, 0, 0);
      cy(0, 1, OP_JAL, 0, 0); chk("jal", obs, V_JAL);
      // unsupported branch funct3 faults and stays faulted
      cy(0, 1, OP_BR, 4, 1);  chk("blt_fetch", obs, V_FETCH_GO);
      cy(0, 1, OP_BR, 4, 1);  cy(0, 1, OP_BR, 4, 1); chk("blt_branch", obs, V_BR_N);
      cy(0, 1, OP_BR, 4, 1);  chk("blt_fault", obs, V_FAULT);
      cy(0, 1, OP_R, 0, 0);   chk("fault_hold1", obs, V_FAULT);
      cy(0, 1, OP_R, 0, 0);   chk("fault_hold2", obs, V_FAULT);
      // reset leaves FAULT
      cy(1, 1, OP_R, 0, 0);   cy(1, 1, OP_R, 0, 0); chk("fault_rst", obs, V_RESET);
      // illegal opcode
      cy(0, 1, 7'h00, 0, 0);  cy(0, 1, 7'h00, 0, 0); chk("ill_decode", obs, V_DECODE);
      cy(0, 1, 7'h00, 0, 0);  chk("ill_fault", obs, V_FAULT);
      // reset asserted mid-store suppresses mem_write
      cy(1, 1, OP_SW, 0, 0);  cy(0, 1, OP_SW, 0, 0); cy(0, 1, OP_SW, 0, 0);
      cy(0, 1, OP_SW, 0, 0);  cy(0, 0, OP_SW, 0, 0); chk("rst_mid_memwr", obs, V_MEMWR);
      cy(1, 0, OP_SW, 0, 0);  chk("rst_mid_strobes", obs, V_RESET);
      cy(0, 1, OP_R, 0, 0);   chk("rst_mid_fetch", obs, V_FETCH_GO);
      // watchdog: four low cycles in FETCH -> FAULT
      cy(1, 0, OP_R, 0, 0);   cy(1, 0, OP_R, 0, 0);
      cy(0, 0, OP_R, 0, 0);   chk("wd_wait1", obs, V_FETCH_W);
      cy(0, 0, OP_R, 0, 0);   cy(0, 0, OP_R, 0, 0);
      cy(0, 0, OP_R, 0, 0);   chk("wd_wait4", obs, V_FETCH_W);
      cy(0, 0, OP_R, 0, 0);   chk("wd_fault", obs, V_FAULT);
      // watchdog: mem_ready on the 4th cycle wins
      cy(1, 0, OP_R, 0, 0);   cy(1, 0, OP_R, 0, 0);
      cy(0, 0, OP_R, 0, 0);   cy(0, 0, OP_R, 0, 0); cy(0, 0, OP_R, 0, 0);
      cy(0, 1, OP_R, 0, 0);   chk("wd_late_ready", obs, V_FETCH_GO);
      cy(0, 1, OP_R, 0, 0);   chk("wd_late_decode", obs, V_DECODE);
`ifdef MC_PERF_CNT_EN
      // 17 R-type instructions = 68 cycles; both 4-bit counters wrap
      cy(1, 1, OP_R, 0, 0);   cy(1, 1, OP_R, 0, 0);
      cy(0, 1, OP_R, 0, 0);
      for (int i = 0; i < 68; i++) cy(0, 1, OP_R, 0, 0);
      chk("perf_fetch", obs, V_FETCH_GO);
      chk("perf_retired", retired_cnt, 1);
      chk("perf_cycle", cycle_cnt, 4);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
